shot_clock_ctrl: RTL



---
 rtl/shot_clock_pkg.sv | 51 +++++
 rtl/shot_clock_ctrl_seg7_dec.sv | 18 +
 rtl/shot_clock_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/shot_clock_pkg.sv
// Shared types, 7-segment table and BCD helpers for the shot clock.
package shot_clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_e;

  localparam int MAX_DIGITS = 4;

  // {a,b,c,d,e,f,g}, a in bit 6; entry k is digit k
  localparam logic [9:0][6:0] SEG_TBL = {
    7'h7B, 7'h7F, 7'h70, 7'h5F, 7'h5B,
    7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

  function automatic logic [4*MAX_DIGITS-1:0] int_to_bcd(input int value, input int ndig);
    logic [4*MAX_DIGITS-1:0] res;
    int v;
    res = '0;
    v   = value;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < ndig) begin
        res[4*i +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end
    return res;
  endfunction

  // Ripple-borrow decrement; caller guarantees a nonzero input.
  function automatic logic [4*MAX_DIGITS-1:0] bcd_dec(input logic [4*MAX_DIGITS-1:0] v, input int ndig);
    logic [4*MAX_DIGITS-1:0] res;
    logic borrow;
    res    = v;
    borrow = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < ndig && borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          res[4*i +: 4] = 4'd9;
        end else begin
          res[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/shot_clock_ctrl_seg7_dec.sv
// One BCD digit to active-high 7 segments with active-low lamp test.
module seg7_dec
  import shot_clock_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       lt_n_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h00;
    for (int k = 0; k < 10; k++) begin
      if (bcd_i == 4'(k)) seg_o = SEG_TBL[k];
    end
    if (!lt_n_i) seg_o = 7'h7F;
  end

endmodule

// File: rtl/shot_clock_ctrl.sv
// BCD count-down shot clock with presets, warning, timed horn and latched 7-seg display.
module shot_clock_ctrl
  import shot_clock_pkg::*;
#(
  parameter int DIGITS       = 2,
  parameter int PRESET_FULL  = 24,
  parameter int PRESET_SHORT = 14,
  parameter int WARN_TH      = 5,
  parameter int TICK_DIV     = 10,
  parameter int HORN_CYCLES  = 20
) (
  input  logic                  CP,
  input  logic                  CR,
  input  logic                  CEP,
  input  logic                  CET,
  input  logic                  PE,
  input  logic                  RST_FULL,
  input  logic                  RST_SHORT,
  input  logic [4*DIGITS-1:0]   D,
  input  logic                  LT,
  input  logic                  LE,
  output logic [4*DIGITS-1:0]   num,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  warning,
  output logic                  expired,
  output logic                  horn
);

  localparam int NW = 4*DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HORN_CYCLES+1);

  localparam logic [4*MAX_DIGITS-1:0] FULL16  = int_to_bcd(PRESET_FULL, DIGITS);
  localparam logic [4*MAX_DIGITS-1:0] SHORT16 = int_to_bcd(PRESET_SHORT, DIGITS);
  localparam logic [4*MAX_DIGITS-1:0] WARN16  = int_to_bcd(WARN_TH, DIGITS);
  localparam logic [NW-1:0] FULL_BCD  = FULL16[NW-1:0];
  localparam logic [NW-1:0] SHORT_BCD = SHORT16[NW-1:0];
  localparam logic [NW-1:0] WARN_BCD  = WARN16[NW-1:0];

  logic [NW-1:0] num_q, num_d, disp_q, d_clamp, dec_val;
  logic [4*MAX_DIGITS-1:0] dec_full;
  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [HW-1:0] horn_q, horn_d;
  logic          warn_q, exp_q, en, load;

  assign en = CEP & CET;

  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      d_clamp[4*i +: 4] = (D[4*i +: 4] > 4'd9) ? 4'd9 : D[4*i +: 4];
    end
  end

  assign dec_full = bcd_dec((4*MAX_DIGITS)'(num_q), DIGITS);
  assign dec_val  = dec_full[NW-1:0];

  always_comb begin
    num_d   = num_q;
    state_d = state_q;
    pre_d   = pre_q;
    horn_d  = (horn_q != '0) ? HW'(horn_q - 1'b1) : horn_q;
    load    = 1'b0;
    if (!PE) begin
      num_d = d_clamp;
      load  = 1'b1;
    end else if (RST_FULL) begin
      num_d = FULL_BCD;
      load  = 1'b1;
    end else if (RST_SHORT) begin
      // At or above the short preset the button is ignored for this edge
      if (num_q < SHORT_BCD) begin
        num_d = SHORT_BCD;
        load  = 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE: if (en && num_q != '0) state_d = ST_RUN;
        ST_RUN: begin
          if (!en) begin
            state_d = ST_IDLE;
          end else if (pre_q == PW'(TICK_DIV-1)) begin
            pre_d = '0;
            num_d = dec_val;
            if (num_q == NW'(1)) begin
              state_d = ST_EXPIRED;
              horn_d  = HW'(HORN_CYCLES);
            end
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (load) begin
      pre_d   = '0;
      state_d = ST_IDLE;
      horn_d  = '0;
    end
  end

  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      num_q   <= FULL_BCD;
      state_q <= ST_IDLE;
      pre_q   <= '0;
      horn_q  <= '0;
      warn_q  <= 1'b0;
      exp_q   <= 1'b0;
      disp_q  <= FULL_BCD;
    end else begin
      num_q   <= num_d;
      state_q <= state_d;
      pre_q   <= pre_d;
      horn_q  <= horn_d;
      warn_q  <= (num_d != '0) && (num_d <= WARN_BCD);
      exp_q   <= (state_d == ST_EXPIRED);
      if (!LE) disp_q <= num_d;
    end
  end

  // Latch holds BCD; decoding it combinationally equals a registered decode
  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    seg7_dec u_dec (
      .bcd_i  (disp_q[4*g +: 4]),
      .lt_n_i (LT),
      .seg_o  (seg[7*g +: 7])
    );
  end

  assign num     = num_q;
  assign warning = warn_q;
  assign expired = exp_q;
  assign horn    = (horn_q != '0);

endmodule
